// File: rtl/adder_frame_accumulator.sv
// adder_frame_accumulator: sums NUM_OPS operands per frame, presents sum + sticky carry on a valid/ready handshake.
// Define ADDER_ACC_SATURATE_EN to clamp the accumulator to all ones on carry instead of wrapping.
module adder_frame_accumulator #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int CW = $clog2(NUM_OPS) + 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt, w_s, w_sum;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_cflag, w_cflag_nxt, w_c, w_accept, w_take;
  assign {w_c, w_s} = {1'b0, r_acc} + {1'b0, in_data};
`ifdef ADDER_ACC_SATURATE_EN
  assign w_sum = w_c ? {WIDTH{1'b1}} : w_s;
`else
  assign w_sum = w_s;
`endif
  assign in_ready  = (r_state == ACCUM) && !rst;
  assign out_valid = r_state == HOLD;
  assign out_sum   = r_acc;
  assign out_cout  = r_cflag;
  assign busy      = (r_cnt != '0) || (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_take    = out_valid && out_ready;
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_cflag_nxt = r_cflag;
    if (w_accept) begin
      w_acc_nxt   = w_sum;
      w_cflag_nxt = r_cflag | w_c;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_state_nxt = (r_cnt == CW'(NUM_OPS - 1)) ? HOLD : ACCUM;
    end else if (w_take) begin
      w_acc_nxt   = '0;
      w_cflag_nxt = 1'b0;
      w_cnt_nxt   = '0;
      w_state_nxt = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_cflag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cflag <= w_cflag_nxt;
    end
  end
endmodule

// File: tb/tb_adder_frame_accumulator.sv
// tb_adder_frame_accumulator: directed frames checked against a frame-total model plus literal expectations.
module tb_adder_frame_accumulator;
  localparam int W = 4;
  localparam int N = 4;
`ifdef ADDER_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
  int n_chk = 0;
  int n_fail = 0;
  int m_total = 0;
  int m_cnt = 0;
  bit m_hold = 1'b0;
  bit m_init = 1'b0;
  adder_frame_accumulator #(.WIDTH(W), .NUM_OPS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_sum();
    if (SAT) return (m_total >= (1 << W)) ? (1 << W) - 1 : m_total;
    return m_total % (1 << W);
  endfunction
  // Frame model: only the unbounded total matters; carry seen iff it ever reached 2^W.
  always @(posedge clk) begin
    if (rst) begin
      m_total = 0; m_cnt = 0; m_hold = 1'b0; m_init = 1'b1;
    end else if (m_hold) begin
      if (out_ready) begin m_total = 0; m_cnt = 0; m_hold = 1'b0; end
    end else if (in_valid) begin
      m_total += int'(in_data);
      m_cnt++;
      if (m_cnt == N) m_hold = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_in_ready", 32'(in_ready), 32'(!m_hold && !rst));
      chk("model_out_valid", 32'(out_valid), 32'(m_hold));
      chk("model_out_sum", 32'(out_sum), 32'(exp_sum()));
      chk("model_out_cout", 32'(out_cout), 32'(m_total >= (1 << W)));
      chk("model_busy", 32'(busy), 32'(m_cnt != 0 || m_hold));
    end
  end
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rs);
    in_valid = v; in_data = d; out_ready = r; rst = rs;
    @(posedge clk);
    #2;
  endtask
  initial begin
    step(0, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_sum", 32'(out_sum), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    step(1, 1, 1, 0); step(1, 2, 1, 0); step(1, 3, 1, 0); step(1, 4, 1, 0);
    chk("f1_out_valid", 32'(out_valid), 1);
    chk("f1_out_sum", 32'(out_sum), 10);
    chk("f1_out_cout", 32'(out_cout), 0);
    chk("f1_in_ready_hold", 32'(in_ready), 0);
    step(0, 0, 1, 0);
    chk("f1_taken_valid", 32'(out_valid), 0);
    chk("f1_in_ready_back", 32'(in_ready), 1);
    step(1, 15, 0, 0); step(1, 15, 0, 0);
    chk("f2_acc_after_2", 32'(out_sum), SAT ? 15 : 14);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    chk("f2_out_sum", 32'(out_sum), 15);
    chk("f2_out_cout", 32'(out_cout), 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 7, 0, 0);
      chk("f3_hold_valid", 32'(out_valid), 1);
      chk("f3_hold_sum", 32'(out_sum), SAT ? 15 : 4);
      chk("f3_hold_cout", 32'(out_cout), 1);
      chk("f3_hold_in_ready", 32'(in_ready), 0);
    end
    step(1, 7, 1, 0);
    chk("f3_released", 32'(out_valid), 0);
    chk("f3_cleared_sum", 32'(out_sum), 0);
    step(1, 2, 0, 0); step(1, 3, 0, 0);
    chk("f4_partial_busy", 32'(busy), 1);
    step(0, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("f4_rst_busy", 32'(busy), 0);
    chk("f4_rst_sum", 32'(out_sum), 0);
    chk("f4_rst_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("f4_out_sum", 32'(out_sum), 4);
    chk("f4_out_cout", 32'(out_cout), 0);
    step(0, 0, 1, 0);
    step(1, 6, 0, 0); step(0, 9, 0, 0); step(0, 9, 0, 0);
    chk("f5_gap_sum", 32'(out_sum), 6);
    chk("f5_gap_busy", 32'(busy), 1);
    step(1, 1, 0, 0); step(0, 3, 0, 0); step(1, 8, 0, 0);
    chk("f5_not_done", 32'(out_valid), 0);
    step(1, 2, 0, 0);
    chk("f5_out_valid", 32'(out_valid), 1);
    chk("f5_out_sum", 32'(out_sum), SAT ? 15 : 1);
    chk("f5_out_cout", 32'(out_cout), 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 15, 1, 0);
    chk("f6a_out_sum", 32'(out_sum), SAT ? 15 : 12);
    chk("f6a_out_cout", 32'(out_cout), 1);
    step(1, 9, 1, 0);
    chk("f6_take_no_accept", 32'(out_sum), 0);
    chk("f6_in_ready_after_take", 32'(in_ready), 1);
    step(1, 9, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    chk("f6b_out_sum", 32'(out_sum), 9);
    chk("f6b_out_cout", 32'(out_cout), 0);
    chk("f6b_out_valid", 32'(out_valid), 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("end_idle_busy", 32'(busy), 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_frame_accumulator.md
Name: adder_frame_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit FA/HA adder.
- Accepts a frame of NUM_OPS operands over a valid/ready handshake and sums them into a WIDTH-bit accumulator through one internal combinational adder (adder result feeds the accumulator register each beat).
- Presents the frame sum plus a sticky carry-out flag on an output valid/ready handshake, then clears for the next frame.

Parameters:
- WIDTH, 4, operand and accumulator width in bits (>=1).
- NUM_OPS, 4, operands per frame (>=1); count register is clog2(NUM_OPS)+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  frame sum (modulo 2^WIDTH, or saturated; see Optional Feature).
- out_cout  output  1  sticky: any per-beat carry-out during the frame.
- busy  output  1  at least one operand of the current frame has been accepted and the result has not been taken yet.

Behaviour:
- One clock and one reset: rst is synchronous and active-high, sampled on the rising edge of clk.
- State register has two states: ACCUM and HOLD.
- Reset values: state=ACCUM, acc=0, cnt=0, cflag=0, out_valid=0, out_sum=0, out_cout=0, busy=0.
- in_ready = (state==ACCUM) && !rst. This is combinational, with no dependence on in_valid.
- Accept: in_valid && in_ready at a clock edge. Compute {c, s} = acc + in_data at WIDTH+1 bits, then:
  - acc <= s
  - cflag <= cflag | c
  - cnt <= cnt+1
- out_sum = acc and out_cout = cflag, both directly from registers. They show running values during ACCUM and are qualified only by out_valid.
- Final operand (accept while cnt==NUM_OPS-1): state <= HOLD and out_valid <= 1 on the same edge.
  - Latency: out_valid and the final sum appear the cycle after the last accept.
- HOLD:
  - in_ready=0. in_valid and in_data are ignored and do not alter acc.
  - out_valid, out_sum and out_cout hold stable until out_valid && out_ready.
- Result taken (out_valid && out_ready at an edge): acc<=0, cnt<=0, cflag<=0, out_valid<=0, state<=ACCUM.
  - in_ready rises in the following cycle. There is no same-cycle pass-through.
- in_valid gaps: no accept happens, and all state holds.
- busy = (cnt!=0) || (state==HOLD).
- NUM_OPS=1: every accept goes straight to HOLD, and the sum equals the operand.
- Reset mid-frame or during HOLD: all registers return to reset values on that edge, and the partial frame is discarded.
- rst has priority over an accept or a take on the same edge.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: ADDER_ACC_SATURATE_EN.
- Defined: on a carry (c=1), acc <= all ones (2^WIDTH-1) instead of s, and cflag is still set. Once saturated, acc stays at all ones for the rest of the frame.
- Undefined: modulo-2^WIDTH wrap, exactly as in Behaviour.
- The ports are identical in both builds.

Test Plan (WIDTH=4, NUM_OPS=4):
- Reset, then operands 1,2,3,4 with back-to-back valid, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=4'b1010, out_cout=0; in_ready back to 1 two cycles after final accept.
- Operands 15,15,1,0 -> without macro: out_sum=4'b1111, out_cout=1 (15+15 wraps to 14, then 15, then 15). With ADDER_ACC_SATURATE_EN: out_sum=4'b1111, out_cout=1, and acc reads 15 after the 2nd accept.
- Frame 5,5,5,5 with out_ready held low 3 cycles, in_valid=1 and in_data=7 throughout -> out_sum=4'b0100, out_cout=1, stable for 3 cycles; in_ready=0 and acc unchanged; released on out_ready.
- Operands 2,3 then rst=1 for one cycle, then 1,1,1,1 -> no out_valid from the aborted frame; next result out_sum=4'b0100, out_cout=0, busy=0 right after reset.
- Operands 6,_,_,1,_,8,2 with in_valid idle on the gaps (_) -> accepts only on valid cycles, cnt unchanged on gaps; out_sum=4'b0001, out_cout=1 (17 mod 16).
- Two frames back-to-back, with out_ready=1 at the cycle out_valid rises -> second frame's first accept no earlier than one cycle after the take; second result is independent of the first (cflag cleared).
